// File: rtl/ccg_lut_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ccg_lut_pkg
// Brief    : Shared types and width helpers for the ccg_lut_bank family.
// Revision : 1.0
// ============================================================================
package ccg_lut_pkg;

  localparam int SIG_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sweep_state_e;

  function automatic int tt_width(input int n_in);
    return 1 << n_in;
  endfunction

  function automatic int idx_width(input int n_out);
    return (n_out > 1) ? $clog2(n_out) : 1;
  endfunction

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ccg_lut_eval.sv
`default_nettype none
// ============================================================================
// Module   : ccg_lut_eval
// Brief    : Combinational evaluation of N_OUT truth tables at input vector x.
// Revision : 1.0
// ============================================================================
module ccg_lut_eval
  import ccg_lut_pkg::*;
#(
  parameter  int N_IN  = 3,
  parameter  int N_OUT = 13,
  localparam int TT_W  = tt_width(N_IN)
) (
  input  logic [TT_W-1:0]  tt [N_OUT],
  input  logic [N_IN-1:0]  x,
  output logic [N_OUT-1:0] f
);

  for (genvar j = 0; j < N_OUT; j++) begin : g_out
    assign f[j] = tt[j][x];
  end

endmodule
`default_nettype wire

// File: rtl/ccg_lut_bank.sv
`default_nettype none
// ============================================================================
// Module   : ccg_lut_bank
// Brief    : Runtime-loadable LUT bank with registered sample path and
//            exhaustive sweep. Optional signature output: CCG_LUT_SIG_EN.
// Revision : 1.0
// ============================================================================
module ccg_lut_bank
  import ccg_lut_pkg::*;
#(
  parameter  int N_IN  = 3,
  parameter  int N_OUT = 13,
  localparam int TT_W  = tt_width(N_IN),
  localparam int IDX_W = idx_width(N_OUT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [TT_W-1:0]  cfg_tt,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_x,
  input  logic             sweep_start,
  output logic             busy,
  output logic             sweep_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_IN-1:0]  out_x,
  output logic [N_OUT-1:0] out_f,
  output logic             out_last
`ifdef CCG_LUT_SIG_EN
  ,
  output logic [SIG_W-1:0] sig
`endif
);

  localparam logic [IDX_W:0] c_n_out    = (IDX_W+1)'(N_OUT);
  localparam logic [N_IN:0]  c_last_cnt = (N_IN+1)'(TT_W - 1);
  localparam logic [N_IN:0]  c_cnt_one  = (N_IN+1)'(1);

  sweep_state_e     r_state;
  logic [N_IN:0]    r_cnt;
  logic [TT_W-1:0]  r_tt [N_OUT];
  logic             r_out_sweep;

  logic             w_idle;
  logic             w_sweep;
  logic             w_out_free;
  logic             w_src_valid;
  logic             w_acc;
  logic             w_last;
  logic             w_cfg_hit;
  logic [N_IN-1:0]  w_src_x;
  logic [N_OUT-1:0] w_f;

  assign w_idle      = (r_state == IDLE);
  assign w_sweep     = (r_state == SWEEP);
  assign w_out_free  = ~out_valid | out_ready;
  // A sweep request in IDLE takes priority over a coincident external sample.
  assign w_src_valid = w_sweep | (w_idle & in_valid & ~sweep_start);
  assign w_src_x     = w_sweep ? r_cnt[N_IN-1:0] : in_x;
  assign w_acc       = w_src_valid & w_out_free;
  assign w_last      = w_sweep & (r_cnt == c_last_cnt);
  assign w_cfg_hit   = w_idle & cfg_we & ({1'b0, cfg_idx} < c_n_out);
  assign in_ready    = w_idle & ~sweep_start & w_out_free;

  ccg_lut_eval #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) u_eval (
    .tt (r_tt),
    .x  (w_src_x),
    .f  (w_f)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < N_OUT; j++) r_tt[j] <= '0;
    end else if (w_cfg_hit) begin
      r_tt[cfg_idx] <= cfg_tt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_x       <= '0;
      out_f       <= '0;
      out_last    <= 1'b0;
      r_out_sweep <= 1'b0;
    end else if (w_acc) begin
      out_valid   <= 1'b1;
      out_x       <= w_src_x;
      out_f       <= w_f;
      out_last    <= w_last;
      r_out_sweep <= w_sweep;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      r_out_sweep <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (sweep_start) begin
            r_state <= SWEEP;
            r_cnt   <= '0;
            busy    <= 1'b1;
          end
        end
        SWEEP: begin
          if (w_acc) begin
            r_cnt <= r_cnt + c_cnt_one;
            if (w_last) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_out_free) begin
            r_state    <= DONE;
            busy       <= 1'b0;
            sweep_done <= 1'b1;
          end
        end
        DONE: begin
          r_state    <= IDLE;
          sweep_done <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef CCG_LUT_SIG_EN
  localparam int c_sig_n = min_int(N_OUT, SIG_W);

  logic [SIG_W-1:0] w_sig_f;

  always_comb begin
    w_sig_f              = '0;
    w_sig_f[c_sig_n-1:0] = out_f[c_sig_n-1:0];
  end

  // Only results that originated from the sweep counter fold into the signature.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (w_idle & sweep_start) begin
      sig <= '0;
    end else if (out_valid & out_ready & r_out_sweep) begin
      sig <= {sig[SIG_W-2:0], sig[SIG_W-1]} ^ w_sig_f;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ccg_lut_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_ccg_lut_bank
// Brief    : Self-checking bench for ccg_lut_bank against a truth-table model.
// Revision : 1.0
// ============================================================================
module tb_ccg_lut_bank;

  localparam int N_IN  = 3;
  localparam int N_OUT = 13;
  localparam int TT_W  = 8;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_we = 1'b0;
  logic [IDX_W-1:0] cfg_idx = '0;
  logic [TT_W-1:0]  cfg_tt = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N_IN-1:0]  in_x = '0;
  logic             sweep_start = 1'b0;
  logic             busy;
  logic             sweep_done;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [N_IN-1:0]  out_x;
  logic [N_OUT-1:0] out_f;
  logic             out_last;
`ifdef CCG_LUT_SIG_EN
  logic [31:0]      sig;
`endif

  always #5 clk = ~clk;

  ccg_lut_bank #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_tt      (cfg_tt),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .sweep_start (sweep_start),
    .busy        (busy),
    .sweep_done  (sweep_done),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_x       (out_x),
    .out_f       (out_f),
    .out_last    (out_last)
`ifdef CCG_LUT_SIG_EN
    ,
    .sig         (sig)
`endif
  );

  int total = 0;
  int bad   = 0;

  logic [TT_W-1:0] m_tt [N_OUT];
  logic [31:0]     m_sig;

  typedef struct {
    logic [N_IN-1:0]  x;
    logic [N_OUT-1:0] f;
  } res_t;
  res_t q[$];

  function automatic logic [N_OUT-1:0] model_f(input int x);
    logic [N_OUT-1:0] f;
    for (int j = 0; j < N_OUT; j++) f[j] = m_tt[j][x];
    return f;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int idx, input logic [TT_W-1:0] tt);
    cfg_we  = 1'b1;
    cfg_idx = IDX_W'(idx);
    cfg_tt  = tt;
    next();
    cfg_we  = 1'b0;
    if (idx < N_OUT) m_tt[idx] = tt;
  endtask

  // Leaves the result visible; out_ready stays 1 so the next edge empties it.
  task automatic sample(input logic [N_IN-1:0] x);
    in_valid  = 1'b1;
    in_x      = x;
    out_ready = 1'b1;
    #1;
    chk("sample_in_ready", 64'(in_ready), 64'(1));
    next();
    in_valid = 1'b0;
    chk("sample_valid", 64'(out_valid), 64'(1));
    chk("sample_x", 64'(out_x), 64'(x));
    chk("sample_f", 64'(out_f), 64'(model_f(int'(x))));
  endtask

  task automatic run_sweep(input int mode, input bit inject);
    int n, done_cyc, last_hs;
    bit stall;
    logic [N_IN-1:0]  px;
    logic [N_OUT-1:0] pf;
    logic             pl;
    n = 0; done_cyc = -1; last_hs = -2; stall = 1'b0;
    px = '0; pf = '0; pl = 1'b0;
    m_sig = '0;
    sweep_start = 1'b1;
    out_ready   = 1'b1;
    next();
    sweep_start = 1'b0;
    chk("sweep_busy", 64'(busy), 64'(1));
    for (int cyc = 0; cyc < 200 && done_cyc < 0; cyc++) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (inject && busy) begin
        cfg_we = 1'b1; cfg_idx = IDX_W'(2); cfg_tt = '0;
        in_valid = 1'b1; in_x = N_IN'($urandom); sweep_start = 1'b1;
      end else begin
        cfg_we = 1'b0; in_valid = 1'b0; sweep_start = 1'b0;
      end
      #1;
      if (busy) chk("sweep_in_ready", 64'(in_ready), 64'(0));
      if (stall) begin
        chk("stall_valid", 64'(out_valid), 64'(1));
        chk("stall_x", 64'(out_x), 64'(px));
        chk("stall_f", 64'(out_f), 64'(pf));
        chk("stall_last", 64'(out_last), 64'(pl));
      end
      if (out_valid && out_ready) begin
        if (n < TT_W) begin
          chk("sweep_x", 64'(out_x), 64'(n));
          chk("sweep_f", 64'(out_f), 64'(model_f(n)));
          chk("sweep_last", 64'(out_last), 64'(n == TT_W - 1));
          m_sig = {m_sig[30:0], m_sig[31]} ^ 32'(model_f(n));
        end
        n++;
        last_hs = cyc;
      end
      stall = out_valid && !out_ready;
      px = out_x; pf = out_f; pl = out_last;
      if (sweep_done) done_cyc = cyc;
      next();
    end
    cfg_we = 1'b0; in_valid = 1'b0; sweep_start = 1'b0; out_ready = 1'b1;
    chk("sweep_timeout", 64'(done_cyc >= 0), 64'(1));
    chk("sweep_hs_count", 64'(n), 64'(TT_W));
    chk("sweep_done_lat", 64'(done_cyc), 64'(last_hs + 1));
    chk("sweep_done_pulse", 64'(sweep_done), 64'(0));
    chk("sweep_busy_end", 64'(busy), 64'(0));
`ifdef CCG_LUT_SIG_EN
    chk("sweep_sig", 64'(sig), 64'(m_sig));
`endif
  endtask

  initial begin
    int widx;
    bit hit;
    res_t r;
    for (int j = 0; j < N_OUT; j++) m_tt[j] = '0;
    m_sig = '0;

    // Reset state
    repeat (2) next();
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_x", 64'(out_x), 64'(0));
    chk("rst_f", 64'(out_f), 64'(0));
    chk("rst_last", 64'(out_last), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(sweep_done), 64'(0));
    rst_n = 1'b1;
    next();
    chk("idle_in_ready", 64'(in_ready), 64'(1));
    sample(N_IN'($urandom));
    next();

    // Directed single-sample evaluation
    cfg_write(2, 8'hF0);
    cfg_write(8, 8'hCC);
    sample(3'b101);
    chk("t1_f3", 64'(out_f[2]), 64'(1));
    chk("t1_f9", 64'(out_f[8]), 64'(0));
    chk("t1_x", 64'(out_x), 64'(3'b101));
    next();
    chk("t1_drained", 64'(out_valid), 64'(0));

    // Sweeps: full rate, 1-0-0 stall pattern, random stalls with ignored traffic
    cfg_write(3, 8'h57);
    run_sweep(0, 1'b0);
    run_sweep(1, 1'b0);
    run_sweep(2, 1'b1);
    sample(3'b101);
    chk("t4_tt_kept", 64'(out_f[2]), 64'(1));
    next();

    // Same-cycle write and sample: sample sees the old table
    cfg_we = 1'b1; cfg_idx = IDX_W'(2); cfg_tt = 8'h0F;
    in_valid = 1'b1; in_x = 3'b101; out_ready = 1'b1;
    #1;
    chk("t5_in_ready", 64'(in_ready), 64'(1));
    next();
    cfg_we = 1'b0; in_valid = 1'b0;
    chk("t5_old_tt", 64'(out_f[2]), 64'(1));
    m_tt[2] = 8'h0F;
    sample(3'b101);
    chk("t5_new_tt", 64'(out_f[2]), 64'(0));
    next();

    // Randomized stream with random backpressure and config writes
    for (int c = 0; c < 300; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_x      = N_IN'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cfg_we    = ($urandom_range(0, 7) == 0);
      widx      = int'($urandom_range(0, 15));
      cfg_idx   = IDX_W'(widx);
      cfg_tt    = TT_W'($urandom);
      #1;
      chk("stream_in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        chk("stream_q_nonempty", 64'(q.size() > 0), 64'(1));
        if (q.size() > 0) begin
          r = q.pop_front();
          chk("stream_x", 64'(out_x), 64'(r.x));
          chk("stream_f", 64'(out_f), 64'(r.f));
        end
      end
      if (in_valid && in_ready) q.push_back('{x: in_x, f: model_f(int'(in_x))});
      if (cfg_we && widx < N_OUT) m_tt[widx] = cfg_tt;
      next();
    end
    in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (out_valid && out_ready && q.size() > 0) begin
        r = q.pop_front();
        chk("stream_x", 64'(out_x), 64'(r.x));
        chk("stream_f", 64'(out_f), 64'(r.f));
      end
      next();
    end
    chk("stream_empty", 64'(q.size()), 64'(0));

    // Sweep over freshly randomized tables for every output
    for (int j = 0; j < N_OUT; j++) cfg_write(j, TT_W'($urandom));
    run_sweep(2, 1'b0);

    // Asynchronous reset in the middle of a sweep
    sweep_start = 1'b1; out_ready = 1'b1;
    next();
    sweep_start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      if (out_valid && out_x == 3'd3) hit = 1'b1;
      else next();
    end
    chk("t6_reach_cnt4", 64'(hit), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 64'(out_valid), 64'(0));
    chk("t6_busy", 64'(busy), 64'(0));
    chk("t6_done", 64'(sweep_done), 64'(0));
    chk("t6_f", 64'(out_f), 64'(0));
    next();
    rst_n = 1'b1;
    for (int j = 0; j < N_OUT; j++) m_tt[j] = '0;
`ifdef CCG_LUT_SIG_EN
    chk("t6_sig", 64'(sig), 64'(0));
`endif
    hit = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (sweep_done || busy) hit = 1'b1;
      next();
    end
    chk("t6_no_done", 64'(hit), 64'(0));
    sample(N_IN'($urandom));
    chk("t6_f_cleared", 64'(out_f), 64'(0));
    next();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
